fetch_unit: RTL

Instruction-fetch stage of the pipelined MIPS core: owns the PC, issues single-outstanding requests to instruction memory, and loads the IF/ID pipeline register. It is the consumer of the hazard unit's stall controls (`pc_write`, `if_id_write`) and of the ID-stage branch/jump redirect. It holds, bubbles and flushes IF/ID so that stalls and taken branches never lose or duplicate an instruction.

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit_if_id_reg.sv | 32 +++
 rtl/fetch_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } fetch_state_t;

    localparam logic [31:0] NOP_INS          = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;

    // Modulo-2^32 increment; low address bits are carried through untouched.
    function automatic logic [31:0] pc_plus4(input logic [31:0] p);
        return p + PC_INCR;
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// rtl/fetch_unit_if_id_reg.sv - IF/ID pipeline register {ins, pc4, valid} with load/bubble/hold
module if_id_reg
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] ins_d,
    input  logic [31:0] pc4_d,
    output logic [31:0] ins,
    output logic [31:0] pc4,
    output logic        valid
);

    // Load wins over bubble; neither asserted means hold. A bubble keeps pc4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ins   <= NOP_INS;
            pc4   <= 32'h0;
            valid <= 1'b0;
        end else if (load) begin
            ins   <= ins_d;
            pc4   <= pc4_d;
            valid <= 1'b1;
        end else if (bubble) begin
            ins   <= NOP_INS;
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, single-outstanding imem request FSM, hold buffer and IF/ID load control
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write,
    input  logic        if_id_write,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] if_id_ins,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_q, hold_d;
    logic         req_q;
    logic [31:0]  addr_q;
    logic         advance;
    logic         deliver;
    logic [31:0]  deliver_ins;
    logic         ifid_bubble;
    logic [31:0]  pc4_cur;

    assign advance = pc_write & if_id_write;
    assign pc4_cur = pc_plus4(pc_q);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_d      = hold_q;
        deliver     = 1'b0;
        deliver_ins = imem_rdata;

        case (state_q)
            ST_IDLE: begin
                if (redirect) pc_d = redirect_pc;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    // A response arriving with the redirect is simply thrown away;
                    // otherwise it is still in flight and must be swallowed later.
                    pc_d    = redirect_pc;
                    state_d = imem_rvalid ? ST_REQ : ST_DROP;
                end else if (imem_rvalid) begin
                    if (advance) begin
                        deliver = 1'b1;
                        pc_d    = pc4_cur;
                        state_d = ST_REQ;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                deliver_ins = hold_q;
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = ST_REQ;
                end else if (advance) begin
                    deliver = 1'b1;
                    pc_d    = pc4_cur;
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (redirect) pc_d = redirect_pc;
                if (imem_rvalid) state_d = ST_REQ;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request strobe and address are registered from next-state so they are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            hold_q  <= NOP_INS;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            req_q   <= (state_d == ST_REQ);
            addr_q  <= pc_d;
        end
    end

    assign ifid_bubble = redirect | (if_id_write & ~deliver);

    if_id_reg u_if_id_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (deliver),
        .bubble (ifid_bubble),
        .ins_d  (deliver_ins),
        .pc4_d  (pc4_cur),
        .ins    (if_id_ins),
        .pc4    (if_id_pc4),
        .valid  (if_id_valid)
    );

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign pc        = pc_q;

endmodule
